// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Counter must hold values 0..w, so it needs clog2(w+1) bits (at least one).
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = $clog2(w + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single-bit full adder cell shared across every bit position of the serial adder.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell, one bit per clock, LSB first.
// Optional subtraction mode enabled by defining SERIAL_ADD_SUB_EN (adds port sub).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sub_req;
  logic               fa_s;
  logic               fa_co;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_req = sub;
`else
  assign sub_req = 1'b0;
`endif

  fa_bit u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .co  (fa_co)
  );

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      ST_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // Publish only the completed word so sum never shows partial results.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = fa_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // Unused encoding behaves as IDLE.
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = sub_req ? ~b : b;
          carry_d = sub_req;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed table, corner sequences, random ops vs arithmetic model.
module tb_serial_add_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on a (W+1)-bit result.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  // Full transaction from a negedge in IDLE: start at E0, result after E_W, idle after E_W+1.
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, input logic [W-1:0] es, input logic ec);
    a = x; b = y; sub = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~x; b = ~y;
    check({name, "_busy_e0"}, 32'(busy), 32'd1);
    check({name, "_done_e0"}, 32'(done), 32'd0);
    for (int k = 1; k < int'(W); k++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_sum"}, 32'(sum), 32'(prev_sum));
      check({name, "_hold_cout"}, 32'(cout), 32'(prev_cout));
      check({name, "_nodone"}, 32'(done), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_done"}, 32'(busy), 32'd1);
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_cout"}, 32'(cout), 32'(ec));
    @(posedge clk);
    @(negedge clk);
    check({name, "_done_clr"}, 32'(done), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
    prev_sum  = es;
    prev_cout = ec;
  endtask

  vec_t tbl [6];

  initial begin
    int ndone;
    int last_k;
    logic [W-1:0] rx, ry;
    logic         rs;
    logic [W:0]   r;

    tbl[0] = '{a: 4'h3, b: 4'h5, exp_sum: 4'h8, exp_cout: 1'b0};
    tbl[1] = '{a: 4'hF, b: 4'h1, exp_sum: 4'h0, exp_cout: 1'b1};
    tbl[2] = '{a: 4'hA, b: 4'h5, exp_sum: 4'hF, exp_cout: 1'b0};
    tbl[3] = '{a: 4'h8, b: 4'h8, exp_sum: 4'h0, exp_cout: 1'b1};
    tbl[4] = '{a: 4'h0, b: 4'h0, exp_sum: 4'h0, exp_cout: 1'b0};
    tbl[5] = '{a: 4'hF, b: 4'hF, exp_sum: 4'hE, exp_cout: 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    prev_sum = '0; prev_cout = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp_sum, tbl[i].exp_cout);

    // Asynchronous reset mid-RUN with cnt==2.
    a = 4'h3; b = 4'h5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_hold_busy", 32'(busy), 32'd0);
    prev_sum = '0; prev_cout = 1'b0;
    @(negedge clk);
    run_op("post_rst", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);

    // Start while busy is ignored.
    a = 4'h2; b = 4'h2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 4'h1; b = 4'h1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ign_sum", 32'(sum), 32'h4);
        check("ign_cout", 32'(cout), 32'd0);
      end
    end
    check("ign_done_count", 32'(ndone), 32'd1);
    check("ign_idle", 32'(busy), 32'd0);
    prev_sum = 4'h4; prev_cout = 1'b0;

    // Back-to-back with start held high: one result per W+2 cycles.
    a = 4'h7; b = 4'h6; start = 1'b1;
    ndone = 0; last_k = -1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        ndone++;
        check("b2b_sum", 32'(sum), 32'hD);
        check("b2b_cout", 32'(cout), 32'd0);
        if (last_k >= 0) check("b2b_gap", 32'(k - last_k), 32'(W + 2));
        else             check("b2b_first", 32'(k), 32'(W));
        last_k = k;
      end
    end
    start = 1'b0;
    check("b2b_count", 32'(ndone), 32'd4);
    for (int k = 0; k < 10 && busy; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("b2b_idle", 32'(busy), 32'd0);
    prev_sum = 4'hD; prev_cout = 1'b0;

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_5m3", 4'h5, 4'h3, 1'b1, 4'h2, 1'b1);
    run_op("sub_3m5", 4'h3, 4'h5, 1'b1, 4'hE, 1'b0);
    run_op("sub0_3p5", 4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
`endif

    for (int i = 0; i < 20; i++) begin
      rx = W'($urandom_range(0, (1 << W) - 1));
      ry = W'($urandom_range(0, (1 << W) - 1));
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      r = model(rx, ry, rs);
      run_op($sformatf("rnd%0d", i), rx, ry, rs, r[W-1:0], r[W]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer: time-multiplexes one single-bit full-adder cell across a WIDTH-bit operand pair, one bit per clock, LSB first. Start/busy/done handshake; result and carry registered. Sits between the switch inputs and the LED outputs in place of a parallel multi-bit adder. Trades latency for one adder cell.

Parameters:
WIDTH, 4, operand/result width in bits (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A, captured on start
b  input  WIDTH  operand B, captured on start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
sum  output  WIDTH  registered result
cout  output  1  registered carry out of MSB

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, cout=0, shift regs/carry/counter=0. Operation in flight is discarded, not resumed.
- FSM IDLE(00) / RUN(01) / DONE(10); 11 unreachable, decodes to IDLE.
- IDLE: start=1 at edge E0 -> capture a,b into shift regs a_sr,b_sr; carry<=0; cnt<=0; state<=RUN. start=0 -> stay.
- RUN, each edge: fa_bit(a_sr[0], b_sr[0], carry) -> s,co; s shifted into MSB of res_sr; a_sr,b_sr shift right; carry<=co; cnt<=cnt+1. On the edge where cnt==WIDTH-1: sum<=completed result, cout<=co, state<=DONE.
- Timing: bits processed on edges E1..E_WIDTH; done=1 for exactly the cycle after E_WIDTH; DONE->IDLE unconditionally on next edge.
- busy=1 in RUN and DONE. start while busy is ignored (not queued). a/b changes after E0 are ignored.
- sum/cout hold the previous result until the E_WIDTH update; never show partial results.
- start held high continuously: back-to-back operations, one result per WIDTH+2 cycles.
- Arithmetic: unsigned modulo 2^WIDTH; overflow reported only via cout.
- cnt width = clog2(WIDTH+1); WIDTH=1 legal (single RUN cycle).

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined: extra input port sub (1 bit), captured with a/b on start. sub=1 -> b captured inverted, initial carry=1, giving a-b modulo 2^WIDTH; cout=1 means no borrow (a>=b). sub=0 -> addition as above.
- Undefined: no sub port; addition only; behaviour exactly as Behaviour section.

Decomposition:
- Package serial_add_pkg: state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10), state width constant, clog2-based counter-width function.
- Sub-module fa_bit: purely combinational one-bit full adder (a, b, cin -> s, co); instantiated once. All sequencing, shift regs, counter in serial_add_ctrl.

Test Plan:
- WIDTH=4; rst_n low for 2 cycles mid-RUN (cnt=2) -> busy=0, done=0, sum=0, cout=0 immediately (asynchronous); after release, start a=3,b=5 -> sum=8,cout=0.
- a=4'h3, b=4'h5, start 1-cycle pulse at E0 -> busy from E0, done high only in cycle after E4, sum=4'h8, cout=0; sum still shows old value during E1..E3.
- a=4'hF, b=4'h1 -> sum=4'h0, cout=1; a=4'hF, b=4'hF -> sum=4'hE, cout=1.
- start a=2,b=2; at E2 pulse start with a=1,b=1 -> second request ignored, single done, sum=4'h4; no extra done.
- start held high, a=4'h7, b=4'h6 -> done pulses every 6 cycles, each sum=4'hD, cout=0.
- SERIAL_ADD_SUB_EN defined: sub=1, a=5, b=3 -> sum=4'h2, cout=1; sub=1, a=3, b=5 -> sum=4'hE, cout=0; sub=0 regression of 3+5=8.
